// File: rtl/fault_campaign_seq_if.sv
// Campaign sequencer bus: control, stimulus/response and result stream.
// master = sequencer, slave = campaign environment (stimulus generator, netlist, result sink).
interface fault_campaign_seq_if #(
    parameter int unsigned FID_W  = 10,
    parameter int unsigned STEP_W = 10,
    parameter int unsigned OUT_W  = 3
);
    logic              start;
    logic [FID_W-1:0]  fid_start;
    logic [FID_W-1:0]  fid_end;
    logic [FID_W-1:0]  fault_id;
    logic [STEP_W-1:0] stim_idx;
    logic              stim_valid;
    logic [OUT_W-1:0]  dut_out;
    logic              res_valid;
    logic              res_ready;
    logic [FID_W-1:0]  res_fid;
    logic              res_detected;
    logic [STEP_W-1:0] res_first_step;
    logic              busy;
    logic              done;
    logic [FID_W:0]    detect_count;

    modport master (
        input  start, fid_start, fid_end, dut_out, res_ready,
        output fault_id, stim_idx, stim_valid, res_valid, res_fid, res_detected,
               res_first_step, busy, done, detect_count
    );

    modport slave (
        output start, fid_start, fid_end, dut_out, res_ready,
        input  fault_id, stim_idx, stim_valid, res_valid, res_fid, res_detected,
               res_first_step, busy, done, detect_count
    );
endinterface

// File: rtl/fault_campaign_seq.sv
// Fault-injection campaign sequencer: golden MISR pass, then one replay per fault ID with a result stream.
// Optional macro FSEQ_GOLDEN_TRACE_EN: golden trace RAM, per-step compare and early abort on first mismatch.
module fault_campaign_seq #(
    parameter int unsigned       FID_W = 10,
    parameter int unsigned       STEPS = 1024,
    parameter int unsigned       OUT_W = 3,
    parameter int unsigned       SIG_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
    parameter logic [SIG_W-1:0]  SEED  = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    fault_campaign_seq_if.master bus
);
    localparam int unsigned       STEP_W    = $clog2(STEPS);
    localparam int unsigned       CNT_W     = FID_W + 1;
    localparam logic [FID_W-1:0]  FID_NONE  = '1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_NONE = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {S_IDLE, S_GOLD, S_FRUN, S_REPORT, S_DONE} state_t;

    state_t            r_state;
    logic [FID_W-1:0]  r_cur_fid;
    logic [FID_W-1:0]  r_fid_end;
    logic              r_empty;
    logic [FID_W-1:0]  r_fault_id;
    logic [STEP_W-1:0] r_stim_idx;
    logic              r_stim_valid;
    logic              r_res_valid;
    logic [FID_W-1:0]  r_res_fid;
    logic              r_res_detected;
    logic [STEP_W-1:0] r_res_first_step;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_detect_count;
    logic [SIG_W-1:0]  r_misr;
    logic [SIG_W-1:0]  r_gold_sig;

    logic [OUT_W-1:0]  w_dut_out;
    logic [SIG_W-1:0]  w_misr_next;
    logic              w_last;
    logic              w_pass_end;
    logic              w_detect;
    logic [STEP_W-1:0] w_first_step;
    logic [FID_W-1:0]  w_fid_inc;

    assign w_dut_out   = bus.dut_out;
    assign w_misr_next = {r_misr[SIG_W-2:0], 1'b0} ^ (r_misr[SIG_W-1] ? POLY : '0) ^ SIG_W'(w_dut_out);
    assign w_last      = (r_stim_idx == STEP_LAST);
    assign w_fid_inc   = r_cur_fid + FID_W'(1);

`ifdef FSEQ_GOLDEN_TRACE_EN
    logic [OUT_W-1:0] r_trace [STEPS];
    logic             w_step_miss;

    // Golden responses recorded for exact per-step comparison during fault passes
    always_ff @(posedge clk) begin
        if (r_state == S_GOLD) r_trace[r_stim_idx] <= w_dut_out;
    end

    assign w_step_miss  = (w_dut_out != r_trace[r_stim_idx]);
    assign w_pass_end   = w_last | w_step_miss;
    assign w_detect     = w_step_miss | (w_misr_next != r_gold_sig);
    assign w_first_step = w_step_miss ? r_stim_idx : STEP_NONE;
`else
    assign w_pass_end   = w_last;
    assign w_detect     = (w_misr_next != r_gold_sig);
    assign w_first_step = STEP_NONE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cur_fid        <= '0;
            r_fid_end        <= '0;
            r_empty          <= 1'b0;
            r_fault_id       <= FID_NONE;
            r_stim_idx       <= '0;
            r_stim_valid     <= 1'b0;
            r_res_valid      <= 1'b0;
            r_res_fid        <= '0;
            r_res_detected   <= 1'b0;
            r_res_first_step <= STEP_NONE;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_detect_count   <= '0;
            r_misr           <= SEED;
            r_gold_sig       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_fid_end      <= bus.fid_end;
                        r_empty        <= (bus.fid_start >= bus.fid_end);
                        r_cur_fid      <= bus.fid_start;
                        r_misr         <= SEED;
                        r_stim_idx     <= '0;
                        r_detect_count <= '0;
                        r_stim_valid   <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= S_GOLD;
                    end
                end
                // stim_idx wraps to 0 on the last step, ready for the first fault pass
                S_GOLD: begin
                    r_misr     <= w_misr_next;
                    r_stim_idx <= r_stim_idx + STEP_W'(1);
                    if (w_last) begin
                        r_gold_sig <= w_misr_next;
                        r_misr     <= SEED;
                        if (r_empty) begin
                            r_stim_valid <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_fault_id <= r_cur_fid;
                            r_state    <= S_FRUN;
                        end
                    end
                end
                S_FRUN: begin
                    r_misr     <= w_misr_next;
                    r_stim_idx <= r_stim_idx + STEP_W'(1);
                    if (w_pass_end) begin
                        r_misr           <= SEED;
                        r_stim_idx       <= '0;
                        r_stim_valid     <= 1'b0;
                        r_res_valid      <= 1'b1;
                        r_res_fid        <= r_cur_fid;
                        r_res_detected   <= w_detect;
                        r_res_first_step <= w_first_step;
                        r_state          <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_res_detected && (r_detect_count != CNT_MAX))
                            r_detect_count <= r_detect_count + CNT_W'(1);
                        r_cur_fid <= w_fid_inc;
                        if (w_fid_inc == r_fid_end) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_fault_id   <= w_fid_inc;
                            r_stim_valid <= 1'b1;
                            r_state      <= S_FRUN;
                        end
                    end
                end
                S_DONE: begin
                    r_busy     <= 1'b0;
                    r_fault_id <= FID_NONE;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.fault_id       = r_fault_id;
    assign bus.stim_idx       = r_stim_idx;
    assign bus.stim_valid     = r_stim_valid;
    assign bus.res_valid      = r_res_valid;
    assign bus.res_fid        = r_res_fid;
    assign bus.res_detected   = r_res_detected;
    assign bus.res_first_step = r_res_first_step;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.detect_count   = r_detect_count;
endmodule

// File: tb/tb_fault_campaign_seq.sv
// Scoreboard bench for fault_campaign_seq: a table-driven netlist model, a pass-level reference
// model of each campaign, and a negedge monitor that checks results and done pulses.
module tb_fault_campaign_seq;
    localparam int unsigned       FID_W     = 10;
    localparam int unsigned       STEPS     = 1024;
    localparam int unsigned       STEP_W    = $clog2(STEPS);
    localparam int unsigned       OUT_W     = 3;
    localparam int unsigned       SIG_W     = 16;
    localparam logic [SIG_W-1:0]  POLY      = 16'h1021;
    localparam logic [SIG_W-1:0]  SEED      = 16'hFFFF;
    localparam logic [FID_W-1:0]  FID_NONE  = '1;
    localparam logic [STEP_W-1:0] STEP_ONES = '1;
    localparam int                NFID      = 1 << FID_W;
    localparam int                LIMIT     = 20000;

    typedef struct packed {
        logic [FID_W-1:0]  fid;
        logic              det;
        logic [STEP_W-1:0] first;
    } res_t;

    typedef struct packed {
        logic [FID_W:0] cnt;
        logic [31:0]    cycles;
        logic           chk;
    } done_t;

    logic clk = 1'b0;
    logic rst;

    fault_campaign_seq_if #(.FID_W(FID_W), .STEP_W(STEP_W), .OUT_W(OUT_W)) bif ();

    fault_campaign_seq #(
        .FID_W(FID_W), .STEPS(STEPS), .OUT_W(OUT_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    always #5 clk = ~clk;

    logic [OUT_W-1:0] gold_tab  [STEPS];
    int               flip_idx  [NFID];
    logic [OUT_W-1:0] flip_mask [NFID];

    res_t  res_q [$];
    done_t done_q [$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    done_cnt = 0;
    int    ready_mode = 1;

    // Netlist stand-in: golden table plus a per-fault single-step bit flip
    always_comb begin
        bif.dut_out = gold_tab[bif.stim_idx];
        if (bif.fault_id != FID_NONE && int'(bif.stim_idx) == flip_idx[bif.fault_id])
            bif.dut_out = bif.dut_out ^ flip_mask[bif.fault_id];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bif.res_ready = 1'b0;
            1:       bif.res_ready = 1'b1;
            default: bif.res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [OUT_W-1:0] model_resp(input int idx, input logic [FID_W-1:0] fid);
        logic [OUT_W-1:0] v;
        v = gold_tab[idx];
        if (fid != FID_NONE && idx == flip_idx[fid]) v = v ^ flip_mask[fid];
        return v;
    endfunction

    function automatic logic [SIG_W-1:0] pass_sig(input logic [FID_W-1:0] fid);
        logic [SIG_W-1:0] s;
        logic             msb;
        s = SEED;
        for (int i = 0; i < STEPS; i++) begin
            msb = s[SIG_W-1];
            s   = (s << 1) ^ SIG_W'(model_resp(i, fid));
            if (msb) s = s ^ POLY;
        end
        return s;
    endfunction

    task automatic clear_faults();
        for (int f = 0; f < NFID; f++) begin
            flip_idx[f]  = 0;
            flip_mask[f] = '0;
        end
    endtask

    task automatic start_campaign(input int fs, input int fe, input bit chk_cycles);
        logic [SIG_W-1:0] gsig;
        logic [SIG_W-1:0] fsig;
        res_t  r;
        done_t d;
        int    cycles;
        int    ndet;
        int    first;
        gsig   = pass_sig(FID_NONE);
        cycles = 1 + STEPS + 1;
        ndet   = 0;
        for (int f = fs; f < fe; f++) begin
            fsig  = pass_sig(FID_W'(f));
            first = -1;
            for (int i = 0; i < STEPS && first < 0; i++)
                if (model_resp(i, FID_W'(f)) != model_resp(i, FID_NONE)) first = i;
            r.fid = FID_W'(f);
`ifdef FSEQ_GOLDEN_TRACE_EN
            r.det   = (first >= 0);
            r.first = (first >= 0) ? STEP_W'(first) : STEP_ONES;
            cycles += ((first >= 0) ? first + 1 : STEPS) + 1;
`else
            r.det   = (fsig != gsig);
            r.first = STEP_ONES;
            cycles += STEPS + 1;
`endif
            ndet += int'(r.det);
            res_q.push_back(r);
        end
        d.cnt    = (FID_W+1)'(ndet);
        d.cycles = 32'(cycles);
        d.chk    = chk_cycles;
        done_q.push_back(d);
        @(posedge clk); #1;
        bif.fid_start = FID_W'(fs);
        bif.fid_end   = FID_W'(fe);
        bif.start     = 1'b1;
        start_cyc     = cyc;
        @(posedge clk); #1;
        bif.start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(bif.busy), 1);
    endtask

    task automatic pulse_start(input int fs, input int fe);
        @(posedge clk); #1;
        bif.fid_start = FID_W'(fs);
        bif.fid_end   = FID_W'(fe);
        bif.start     = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < LIMIT) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt != d0), 1);
        @(negedge clk);
        chk("busy_after_done", 32'(bif.busy), 0);
        chk("done_one_cycle", 32'(bif.done), 0);
    endtask

    task automatic run(input int fs, input int fe, input bit chk_cycles);
        int d0;
        d0 = done_cnt;
        start_campaign(fs, fe, chk_cycles);
        wait_done(d0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_fault_id"},       32'(bif.fault_id), 32'(FID_NONE));
        chk({tag, "_stim_idx"},       32'(bif.stim_idx), 0);
        chk({tag, "_stim_valid"},     32'(bif.stim_valid), 0);
        chk({tag, "_res_valid"},      32'(bif.res_valid), 0);
        chk({tag, "_res_fid"},        32'(bif.res_fid), 0);
        chk({tag, "_res_detected"},   32'(bif.res_detected), 0);
        chk({tag, "_res_first_step"}, 32'(bif.res_first_step), 32'(STEP_ONES));
        chk({tag, "_busy"},           32'(bif.busy), 0);
        chk({tag, "_done"},           32'(bif.done), 0);
        chk({tag, "_detect_count"},   32'(bif.detect_count), 0);
    endtask

    // Monitor: a result is consumed on the edge following a negedge with valid && ready
    always @(negedge clk) begin
        res_t  e;
        done_t d;
        if (!rst) begin
            if (bif.res_valid && bif.res_ready) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 32'(bif.res_fid), 32'(FID_NONE));
                end else begin
                    e = res_q.pop_front();
                    chk("res_fid",        32'(bif.res_fid), 32'(e.fid));
                    chk("res_detected",   32'(bif.res_detected), 32'(e.det));
                    chk("res_first_step", 32'(bif.res_first_step), 32'(e.first));
                end
            end
            if (bif.done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    chk("detect_count", 32'(bif.detect_count), 32'(d.cnt));
                    chk("results_left", 32'(res_q.size()), 0);
                    chk("busy_in_done", 32'(bif.busy), 1);
                    if (d.chk) chk("campaign_cycles", 32'(cyc - start_cyc + 1), d.cycles);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int               n;
        int               d0;
        int               fs;
        int               fe;
        logic [FID_W-1:0] hold_fid;
        logic             hold_det;
        logic [FID_W-1:0] hold_fault;

        bif.start     = 1'b0;
        bif.fid_start = '0;
        bif.fid_end   = '0;
        rst           = 1'b1;
        for (int i = 0; i < STEPS; i++) gold_tab[i] = OUT_W'($urandom);
        clear_faults();
        repeat (3) @(posedge clk);
        #1 chk_reset("in_rst");
        @(negedge clk) rst = 1'b0;
        @(negedge clk) chk_reset("post_rst");

        // No effective faults: every fault undetected
        run(0, 4, 1);

        // Single flip of bit 0 at step 37 for fault 2 only
        flip_idx[2]  = 37;
        flip_mask[2] = 3'b001;
        run(0, 4, 1);

        // Empty range: golden pass only
        run(5, 5, 1);

        // Result back-pressure
        @(negedge clk) ready_mode = 0;
        d0 = done_cnt;
        start_campaign(0, 3, 0);
        n = 0;
        while (!bif.res_valid && n < 4 * STEPS) begin
            @(negedge clk);
            n++;
        end
        chk("stall_report_reached", 32'(bif.res_valid), 1);
        chk("stall_res_fid0", 32'(bif.res_fid), 0);
        hold_fid   = bif.res_fid;
        hold_det   = bif.res_detected;
        hold_fault = bif.fault_id;
        repeat (20) begin
            @(negedge clk);
            chk("stall_res_valid",    32'(bif.res_valid), 1);
            chk("stall_res_fid",      32'(bif.res_fid), 32'(hold_fid));
            chk("stall_res_detected", 32'(bif.res_detected), 32'(hold_det));
            chk("stall_stim_valid",   32'(bif.stim_valid), 0);
            chk("stall_fault_id",     32'(bif.fault_id), 32'(hold_fault));
        end
        ready_mode = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("release_stim_valid", 32'(bif.stim_valid), 1);
        chk("release_stim_idx",   32'(bif.stim_idx), 0);
        chk("release_fault_id",   32'(bif.fault_id), 1);
        chk("release_res_valid",  32'(bif.res_valid), 0);
        wait_done(d0);

        // Reset in the middle of fault 1's pass, then a clean rerun
        start_campaign(0, 4, 0);
        n = 0;
        while (!(bif.stim_valid && bif.fault_id == 1 && bif.stim_idx == 500) && n < 4 * STEPS) begin
            @(negedge clk);
            n++;
        end
        chk("reached_fid1_idx500", 32'(bif.stim_valid && bif.fault_id == 1 && bif.stim_idx == 500), 1);
        #1 rst = 1'b1;
        #1 chk_reset("mid_rst");
        res_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk) chk_reset("after_mid_rst");
        run(0, 4, 1);

        // start pulses while busy must be ignored
        d0 = done_cnt;
        start_campaign(0, 4, 1);
        n = 0;
        while (bif.stim_idx != 100 && n < 2 * STEPS) begin
            @(negedge clk);
            n++;
        end
        pulse_start(7, 9);
        n = 0;
        while (!bif.res_valid && n < 4 * STEPS) begin
            @(negedge clk);
            n++;
        end
        pulse_start(1, 2);
        wait_done(d0);

        // Randomized tables, ranges and ready pattern; last one has fid_start > fid_end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < STEPS; i++) gold_tab[i] = OUT_W'($urandom);
            for (int f = 0; f < NFID; f++) begin
                flip_idx[f]  = int'($urandom_range(0, STEPS - 1));
                flip_mask[f] = OUT_W'($urandom_range(0, 7));
            end
            if (k == 3) begin
                fs = int'($urandom_range(1, 12));
                fe = fs - 1;
            end else begin
                fs = int'($urandom_range(0, 12));
                fe = fs + int'($urandom_range(1, 4));
            end
            @(negedge clk) ready_mode = 2;
            run(fs, fe, 0);
            @(negedge clk) ready_mode = 1;
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fault_campaign_seq.md
# fault_campaign_seq

Hardware sequencer for gate-level fault-injection campaigns on the router netlist. It runs one fault-free golden pass over STEPS stimulus indices and compresses the observed outport bits into a MISR signature. It then walks fault IDs fid_start..fid_end-1, driving each onto the netlist's fault-select input and replaying the same stimulus. For every fault it reports detected or undetected through a valid/ready result stream.

## Interface
Parameters:
- FID_W, 10, width of fault ID; all-ones value FID_NONE means "no fault injected"
- STEPS, 1024, stimulus indices per pass (power of two, ≥2)
- OUT_W, 3, observed DUT output bits per step
- SIG_W, 16, MISR width
- POLY, 16'h1021, MISR feedback polynomial
- SEED, 16'hFFFF, MISR initial value

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a campaign when idle
- fid_start  in  FID_W  first fault ID, sampled on start
- fid_end  in  FID_W  exclusive last fault ID, sampled on start
- fault_id  out  FID_W  drives netlist fault select
- stim_idx  out  log2(STEPS)  stimulus index presented to the stimulus generator
- stim_valid  out  1  stim_idx is live this cycle
- dut_out  in  OUT_W  DUT response to stim_idx, valid in the same cycle through combinational settle
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_fid  out  FID_W  fault ID of the result
- res_detected  out  1  signature differs from golden
- res_first_step  out  log2(STEPS)  first mismatching step (macro-dependent)
- busy  out  1  campaign in progress
- done  out  1  one-cycle pulse at campaign end
- detect_count  out  FID_W+1  detected faults this campaign, saturating

## Operation
States: IDLE, GOLD, FRUN, REPORT, DONE.
- IDLE: fault_id=FID_NONE. start latches the fid range, sets cur_fid=fid_start, loads MISR=SEED and stim_idx=0, clears detect_count, and enters GOLD. start during any other state is ignored.
- GOLD: stim_valid=1 and fault_id=FID_NONE. Each cycle: MISR ← shift-left(MISR) ^ (MSB ? POLY : 0) ^ zero-extended dut_out, then stim_idx+1. After step STEPS-1: gold_sig←MISR_next. If fid_start ≥ fid_end → DONE, else → FRUN with MISR=SEED and stim_idx=0.
- FRUN: same fold, with fault_id=cur_fid. After step STEPS-1: compare MISR_next with gold_sig, load the result registers, → REPORT.
- REPORT: res_valid=1. Payload is stable until res_ready. On handshake: detect_count+=detected (saturate at all-ones), cur_fid+1. If cur_fid+1==fid_end → DONE, else → FRUN (MISR reset, stim_idx=0).
- DONE: done=1 for one cycle → IDLE.
- fault_id changes only on the FRUN entry edge. The first folded step of each pass is stim_idx 0.
- stim_idx wraps naturally; the wrap edge is the pass-end edge.

## Timing
- Reset values: fault_id=FID_NONE, stim_idx=0, stim_valid=0, res_valid=0, res_fid=0, res_detected=0, res_first_step=all-ones, busy=0, done=0, detect_count=0, internal MISR=SEED, gold_sig=0.
- busy=1 from the cycle after start through the DONE cycle.
- A pass takes exactly STEPS cycles of stim_valid. FRUN end → res_valid occurs the next cycle. The handshake-to-next-FRUN gap is 1 cycle.
- Campaign of N faults with res_ready tied high: 1 + STEPS + N·(STEPS+1) + 1 cycles from start to the done pulse.
- res_ready held low stalls indefinitely; the sequencer does not advance and stim_valid=0.
- rst mid-campaign: every register returns to its reset value immediately. No result is emitted for the interrupted fault.

## Configuration
- FSEQ_GOLDEN_TRACE_EN defined:
  - The golden pass also writes dut_out into a STEPS×OUT_W trace RAM.
  - FRUN compares each step against the trace.
  - On the first mismatch, res_first_step = that index, and the pass aborts at once: → REPORT next cycle with res_detected=1.
  - A signature-only mismatch (no per-step mismatch) cannot occur, since the trace is exact.
- Not defined:
  - No RAM; detection is by signature compare only.
  - res_first_step is always all-ones.
  - Every FRUN lasts the full STEPS cycles. MISR aliasing is accepted.

## Test plan
- Fault ID ignored by the model; fid_start=0, fid_end=4; res_ready=1 → 4 results fid 0..3, all res_detected=0, detect_count=0, done at cycle 1+STEPS+4·(STEPS+1)+1.
- Model inverts dut_out[0] at stim_idx 37 only when fault_id==2; range 0..4 → only fid 2 detected, detect_count=1. With FSEQ_GOLDEN_TRACE_EN: res_first_step=37 and res_valid at pass cycle 38.
- fid_start=5, fid_end=5 → golden pass only; no res_valid; done after 1+STEPS+1 cycles; detect_count=0.
- res_ready low for 20 cycles during REPORT → res_fid/res_detected are stable, stim_valid=0, fault_id is unchanged; on release, the next fault starts 1 cycle after the handshake.
- rst asserted at stim_idx 500 of fid 1 → outputs at reset values the same cycle; a new start reruns golden and produces identical results.
- start pulsed while busy → ignored; campaign results are unchanged.
